// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit in front of a word-wide,
// single-port data memory with synchronous read and whole-word write enable.
//   clk, rst          clock, asynchronous active-low reset
//   req_*             pipeline request (valid, we, funct3, byte addr, wdata)
//   ready             high while idle; requests are accepted on req_valid && ready
//   load_valid        one-cycle pulse with registered, formatted load_data
//   err, err_addr     one-cycle pulse on a rejected request, and its byte address
//   dm_*              word-indexed memory port (addr, write data/enable, read data)
// Word stores complete in one cycle; sub-word stores use a read-modify-write.
module mem_access_unit #(
   parameter int unsigned MEM_BITS = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        ready,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic        err,
   output logic [31:0] err_addr,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_data_in,
   output logic        dm_write_en,
   input  logic [31:0] dm_data_out
);

   typedef enum logic [1:0] {StIdle, StLoadWait, StRmw} state_e;

   state_e                state_q, state_d;
   logic [MEM_BITS-1:0]   idx_q;
   logic [1:0]            off_q;
   logic [2:0]            f3_q;
   logic [15:0]           wdata_q;
   logic                  load_valid_q;
   logic [31:0]           load_data_q;
   logic                  err_q;
   logic [31:0]           err_addr_q;

   logic                  accept;
   logic                  legal;
   logic                  capture;
   logic                  we_raw;
   logic [31:0]           data_in;
   logic [31:0]           addr_out;
   logic [31:0]           load_fmt;
   logic [31:0]           merged;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;

   assign ready  = (state_q == StIdle);
   assign accept = req_valid && ready;

   // Loads accept all five encodings, stores only b/h/w; alignment per size.
   always_comb begin
      legal = 1'b0;
      case (req_funct3)
         3'b000:  legal = 1'b1;
         3'b001:  legal = ~req_addr[0];
         3'b010:  legal = (req_addr[1:0] == 2'b00);
         3'b100:  legal = ~req_we;
         3'b101:  legal = ~req_we & ~req_addr[0];
         default: legal = 1'b0;
      endcase
   end

   // Lane extraction from the memory read word for loads.
   always_comb begin
      byte_sel = 8'h00;
      case (off_q)
         2'd0:    byte_sel = dm_data_out[7:0];
         2'd1:    byte_sel = dm_data_out[15:8];
         2'd2:    byte_sel = dm_data_out[23:16];
         default: byte_sel = dm_data_out[31:24];
      endcase
      half_sel = off_q[1] ? dm_data_out[31:16] : dm_data_out[15:0];
      load_fmt = dm_data_out;
      case (f3_q)
         3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_fmt = {24'h000000, byte_sel};
         3'b101:  load_fmt = {16'h0000, half_sel};
         default: load_fmt = dm_data_out;
      endcase
   end

   // Replace the target lane of the old word with the latched store data.
   always_comb begin
      merged = dm_data_out;
      if (f3_q == 3'b000) begin
         case (off_q)
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (off_q[1]) begin
         merged[31:16] = wdata_q;
      end else begin
         merged[15:0] = wdata_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      we_raw   = 1'b0;
      data_in  = 32'h0;
      capture  = 1'b0;
      addr_out = {{(32-MEM_BITS){1'b0}}, idx_q};
      case (state_q)
         StIdle: begin
            addr_out = {{(32-MEM_BITS){1'b0}}, req_addr[MEM_BITS+1:2]};
            if (accept && legal) begin
               if (!req_we) begin
                  capture = 1'b1;
                  state_d = StLoadWait;
               end else if (req_funct3 == 3'b010) begin
                  we_raw  = 1'b1;
                  data_in = req_wdata;
               end else begin
                  capture = 1'b1;
                  state_d = StRmw;
               end
            end
         end
         StLoadWait: begin
            state_d = StIdle;
         end
         StRmw: begin
            we_raw  = 1'b1;
            data_in = merged;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         off_q        <= 2'b00;
         f3_q         <= 3'b000;
         wdata_q      <= 16'h0;
         load_valid_q <= 1'b0;
         load_data_q  <= 32'h0;
         err_q        <= 1'b0;
         err_addr_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         load_valid_q <= (state_q == StLoadWait);
         err_q        <= accept && !legal;
         if (capture) begin
            idx_q   <= req_addr[MEM_BITS+1:2];
            off_q   <= req_addr[1:0];
            f3_q    <= req_funct3;
            wdata_q <= req_wdata[15:0];
         end
         if (state_q == StLoadWait) begin
            load_data_q <= load_fmt;
         end
         if (accept && !legal) begin
            err_addr_q <= req_addr;
         end
      end
   end

   assign load_valid  = load_valid_q;
   assign load_data   = load_data_q;
   assign err         = err_q;
   assign err_addr    = err_addr_q;
   assign dm_addr     = addr_out;
   assign dm_data_in  = data_in;
   // Gated so an aborting reset can never produce a partial write.
   assign dm_write_en = we_raw & rst;

endmodule
